// File: rtl/ram_access_ctrl.sv
// Request sequencer for the 1Kx8 single-port RAM: registered RAM pin timing, programmable read
// latency capture and a response channel. Define RAM_BURST_EN for multi-beat fill/readback.
module ram_access_ctrl #(
   parameter int unsigned AW     = 10,
   parameter int unsigned DW     = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_wr,
   input  logic [AW-1:0] i_req_addr,
   input  logic [DW-1:0] i_req_wdata,
   input  logic [3:0]    i_req_len,
   output logic          o_rsp_valid,
   output logic [DW-1:0] o_rsp_rdata,
   output logic          o_rsp_last,
   output logic          o_busy,
   output logic [AW-1:0] o_ram_addr,
   output logic [DW-1:0] o_ram_din,
   output logic          o_ram_wr,
   output logic          o_ram_cs,
   input  logic [DW-1:0] i_ram_dout
);

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StCapture} state_e;

   state_e        r_state, w_state_d;
   logic          r_ready, r_busy, r_wr, w_wr_d;
   logic [AW-1:0] r_addr, w_addr_d;
   logic [DW-1:0] r_wdata, w_wdata_d;
   logic [1:0]    r_cnt, w_cnt_d;
   logic          r_ram_cs, r_ram_wr;
   logic          r_rsp_valid, r_rsp_last;
   logic [DW-1:0] r_rsp_rdata;
   logic          w_accept, w_next_beat, w_sample, w_last;

   assign w_accept = r_ready & i_req_valid;

`ifdef RAM_BURST_EN
   logic [3:0] r_beats, w_beats_d;

   // r_beats counts the beats still to run after the current one
   assign w_last = (r_beats == 4'd0);

   always_comb begin
      w_beats_d = r_beats;
      if (w_accept) begin
         w_beats_d = i_req_len;
      end else if (w_next_beat) begin
         w_beats_d = r_beats - 4'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_beats <= 4'd0;
      end else begin
         r_beats <= w_beats_d;
      end
   end
`else
   logic w_unused_len;
   assign w_unused_len = ^i_req_len;
   assign w_last       = 1'b1;
`endif

   always_comb begin
      w_state_d   = r_state;
      w_wr_d      = r_wr;
      w_addr_d    = r_addr;
      w_wdata_d   = r_wdata;
      w_cnt_d     = r_cnt;
      w_next_beat = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_d = StAccess;
               w_wr_d    = i_req_wr;
               w_addr_d  = i_req_addr;
               w_wdata_d = i_req_wdata;
            end
         end
         StAccess: begin
            if (!r_wr) begin
               if (RD_LAT == 0) begin
                  w_state_d = StCapture;
               end else begin
                  w_state_d = StWait;
                  w_cnt_d   = 2'(RD_LAT - 1);
               end
            end else if (w_last) begin
               w_state_d = StIdle;
            end else begin
               w_next_beat = 1'b1;
            end
         end
         StWait: begin
            if (r_cnt == 2'd0) begin
               w_state_d = StCapture;
            end else begin
               w_cnt_d = r_cnt - 2'd1;
            end
         end
         StCapture: begin
            if (w_last) begin
               w_state_d = StIdle;
            end else begin
               w_state_d   = StAccess;
               w_next_beat = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
      if (w_next_beat) begin
         w_addr_d = r_addr + AW'(1);
      end
   end

   // CAPTURE is only entered on the edge where ram_dout is valid
   assign w_sample = (w_state_d == StCapture);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_ready     <= 1'b0;
         r_busy      <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= 2'd0;
         r_ram_cs    <= 1'b0;
         r_ram_wr    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_d;
         r_ready     <= (w_state_d == StIdle);
         r_busy      <= (w_state_d != StIdle);
         r_wr        <= w_wr_d;
         r_addr      <= w_addr_d;
         r_wdata     <= w_wdata_d;
         r_cnt       <= w_cnt_d;
         r_ram_cs    <= (w_state_d == StAccess);
         r_ram_wr    <= (w_state_d == StAccess) & w_wr_d;
         r_rsp_valid <= w_sample;
         r_rsp_last  <= w_sample & w_last;
         if (w_sample) begin
            r_rsp_rdata <= i_ram_dout;
         end
      end
   end

   assign o_req_ready = r_ready;
   assign o_busy      = r_busy;
   assign o_ram_cs    = r_ram_cs;
   assign o_ram_wr    = r_ram_wr;
   assign o_ram_addr  = r_addr;
   assign o_ram_din   = r_wdata;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_last  = r_rsp_last;
   assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 1Kx8 RAM (one-cycle read latency).
module tb_ram_access_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_wr = 1'b0;
   logic [9:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic [3:0] req_len = '0;
   logic       req_ready, rsp_valid, rsp_last, busy, ram_wr, ram_cs;
   logic [7:0] rsp_rdata, ram_din;
   logic [7:0] ram_dout = '0;
   logic [9:0] ram_addr;

   int n_tests = 0;
   int n_fail  = 0;
   int cs_cnt = 0, wr_cnt = 0, rsp_cnt = 0, cs_double = 0;
   bit prev_cs = 1'b0;

   logic [7:0] mem [0:1023];

   always #5 clk = ~clk;

   ram_access_ctrl #(.AW(10), .DW(8), .RD_LAT(1)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_wr    (req_wr),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .i_req_len   (req_len),
      .o_rsp_valid (rsp_valid),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_last  (rsp_last),
      .o_busy      (busy),
      .o_ram_addr  (ram_addr),
      .o_ram_din   (ram_din),
      .o_ram_wr    (ram_wr),
      .o_ram_cs    (ram_cs),
      .i_ram_dout  (ram_dout)
   );

   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_wr) mem[ram_addr] <= ram_din;
         else        ram_dout <= mem[ram_addr];
      end
   end

   always @(negedge clk) begin
      if (ram_cs) begin
         cs_cnt <= cs_cnt + 1;
         if (ram_wr) wr_cnt <= wr_cnt + 1;
         if (prev_cs) cs_double <= cs_double + 1;
      end
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      prev_cs <= ram_cs;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Returns in the ACCESS cycle of the accepted write.
   task automatic do_write(input logic [9:0] a, input logic [7:0] d, input logic [3:0] len,
                           output bit ok);
      wait_ready(ok);
      if (!ok) return;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_len = len;
      tick();
      req_valid = 1'b0;
   endtask

   // Returns in the rsp_valid cycle; lat counts cycles from acceptance.
   task automatic do_read(input logic [9:0] a, output logic [7:0] d, output logic l,
                          output int lat, output bit ok);
      d = '0; l = 1'b0; lat = 0;
      wait_ready(ok);
      if (!ok) return;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = 4'd0;
      tick();
      req_valid = 1'b0;
      ok = 1'b0;
      for (int i = 1; i < 12; i++) begin
         if (rsp_valid) begin
            d = rsp_rdata; l = rsp_last; lat = i; ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_tests++;
         if ({req_ready, busy, rsp_valid, rsp_last, ram_cs, ram_wr} !== 6'b0 ||
             rsp_rdata !== 8'h00 || ram_addr !== 10'd0 || ram_din !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: rdy=%b busy=%b rv=%b rl=%b cs=%b wr=%b rd=%h a=%0d din=%h, all required 0",
                     c, req_ready, busy, rsp_valid, rsp_last, ram_cs, ram_wr, rsp_rdata,
                     ram_addr, ram_din);
         end
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: req_ready=%b busy=%b, required 1 0", req_ready, busy);
      end
   endtask

   task automatic test_write_read();
      bit ok;
      logic [7:0] d;
      logic l;
      int lat, r0;
      do_write(10'd5, 8'h0A, 4'd0, ok);
      n_tests++;
      if (!ok || ram_cs !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 10'd5 || ram_din !== 8'h0A ||
          req_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL write_access: ok=%b cs=%b wr=%b a=%0d din=%h rdy=%b busy=%b, required 1 1 1 5 0a 0 1",
                  ok, ram_cs, ram_wr, ram_addr, ram_din, req_ready, busy);
      end
      tick();
      n_tests++;
      if (ram_cs !== 1'b0 || ram_wr !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL write_done: cs=%b wr=%b rdy=%b, required 0 0 1", ram_cs, ram_wr, req_ready);
      end
      r0 = rsp_cnt;
      do_read(10'd5, d, l, lat, ok);
      n_tests++;
      if (!ok || d !== 8'h0A || l !== 1'b1 || lat !== 3) begin
         n_fail++;
         $display("FAIL read_5: ok=%b data=%h last=%b lat=%0d, required 1 0a 1 3", ok, d, l, lat);
      end
      tick();
      n_tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 8'h0A || rsp_cnt - r0 != 1) begin
         n_fail++;
         $display("FAIL read_pulse: rv=%b rdy=%b rd=%h pulses=%0d, required 0 1 0a 1",
                  rsp_valid, req_ready, rsp_rdata, rsp_cnt - r0);
      end
   endtask

   task automatic test_sweep();
      bit ok;
      logic [7:0] d;
      logic l;
      int lat, c0, w0, dbl0, bad;
      c0 = cs_cnt; w0 = wr_cnt; dbl0 = cs_double; bad = 0;
      for (int k = 0; k <= 200; k++) begin
         do_write(10'(k), 8'(2 * k), 4'd0, ok);
         if (!ok) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL sweep_write_accept: %0d writes timed out, required 0", bad);
      end
      for (int k = 0; k <= 200; k++) begin
         do_read(10'(k), d, l, lat, ok);
         n_tests++;
         if (!ok || d !== 8'(2 * k) || lat !== 3) begin
            n_fail++;
            $display("FAIL sweep_read addr %0d: ok=%b data=%h lat=%0d, required 1 %h 3",
                     k, ok, d, lat, 8'(2 * k));
         end
      end
      tick();
      n_tests++;
      if (cs_cnt - c0 != 402 || wr_cnt - w0 != 201 || cs_double - dbl0 != 0) begin
         n_fail++;
         $display("FAIL sweep_cs: cs=%0d wr=%0d double=%0d, required 402 201 0",
                  cs_cnt - c0, wr_cnt - w0, cs_double - dbl0);
      end
   endtask

   task automatic test_abort();
      bit ok;
      int r0;
      wait_ready(ok);
      r0 = rsp_cnt;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'd7;
      tick();
      req_valid = 1'b0;
      tick();
      n_tests++;
      if (!ok || busy !== 1'b1 || ram_cs !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_in_wait: ok=%b busy=%b cs=%b rv=%b, required 1 1 0 0",
                  ok, busy, ram_cs, rsp_valid);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (ram_cs !== 1'b0 || ram_wr !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
          req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_reset: cs=%b wr=%b busy=%b rv=%b rdy=%b, required all 0",
                  ram_cs, ram_wr, busy, rsp_valid, req_ready);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_release: rdy=%b busy=%b, required 1 0", req_ready, busy);
      end
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (rsp_cnt - r0 != 0) begin
         n_fail++;
         $display("FAIL abort_no_rsp: %0d responses, required 0", rsp_cnt - r0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [7:0] d;
      logic l;
      int lat, w0;
      wait_ready(ok);
      w0 = wr_cnt;
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'd100; req_wdata = 8'h33;
      tick();
      req_addr = 10'd101; req_wdata = 8'h44;
      #1;
      n_tests++;
      if (!ok || req_ready !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== 10'd100 ||
          ram_din !== 8'h33) begin
         n_fail++;
         $display("FAIL b2b_first: ok=%b rdy=%b cs=%b a=%0d din=%h, required 1 0 1 100 33",
                  ok, req_ready, ram_cs, ram_addr, ram_din);
      end
      tick();
      n_tests++;
      if (req_ready !== 1'b1 || ram_cs !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_gap: rdy=%b cs=%b, required 1 0", req_ready, ram_cs);
      end
      tick();
      req_valid = 1'b0;
      n_tests++;
      if (req_ready !== 1'b0 || ram_cs !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 10'd101 ||
          ram_din !== 8'h44) begin
         n_fail++;
         $display("FAIL b2b_second: rdy=%b cs=%b wr=%b a=%0d din=%h, required 0 1 1 101 44",
                  req_ready, ram_cs, ram_wr, ram_addr, ram_din);
      end
      tick();
      tick();
      n_tests++;
      if (wr_cnt - w0 != 2 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_count: writes=%0d rdy=%b, required 2 1", wr_cnt - w0, req_ready);
      end
      do_read(10'd100, d, l, lat, ok);
      n_tests++;
      if (!ok || d !== 8'h33) begin
         n_fail++;
         $display("FAIL b2b_read100: ok=%b data=%h, required 1 33", ok, d);
      end
      do_read(10'd101, d, l, lat, ok);
      n_tests++;
      if (!ok || d !== 8'h44) begin
         n_fail++;
         $display("FAIL b2b_read101: ok=%b data=%h, required 1 44", ok, d);
      end
   endtask

`ifdef RAM_BURST_EN
   task automatic test_burst();
      bit ok;
      int nacc, nrsp;
      logic [9:0] exp_a [4];
      exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
      do_write(10'd1020, 8'hFF, 4'd7, ok);
      for (int j = 0; j < 8; j++) begin
         n_tests++;
         if (!ok || ram_cs !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 10'((1020 + j) % 1024) ||
             ram_din !== 8'hFF) begin
            n_fail++;
            $display("FAIL fill_beat %0d: ok=%b cs=%b wr=%b a=%0d din=%h, required 1 1 1 %0d ff",
                     j, ok, ram_cs, ram_wr, ram_addr, ram_din, (1020 + j) % 1024);
         end
         tick();
      end
      n_tests++;
      if (ram_cs !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_end: cs=%b rdy=%b, required 0 1", ram_cs, req_ready);
      end
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'd1022; req_len = 4'd3;
      tick();
      req_valid = 1'b0; req_len = 4'd0;
      nacc = 0; nrsp = 0;
      for (int c = 0; c < 30; c++) begin
         if (ram_cs) begin
            n_tests++;
            if (nacc > 3 || ram_addr !== exp_a[nacc[1:0]] || ram_wr !== 1'b0) begin
               n_fail++;
               $display("FAIL rdburst_addr beat %0d: a=%0d wr=%b, required %0d 0",
                        nacc, ram_addr, ram_wr, exp_a[nacc[1:0]]);
            end
            nacc++;
         end
         if (rsp_valid) begin
            n_tests++;
            if (rsp_rdata !== 8'hFF || rsp_last !== (nrsp == 3)) begin
               n_fail++;
               $display("FAIL rdburst_rsp beat %0d: data=%h last=%b, required ff %b",
                        nrsp, rsp_rdata, rsp_last, nrsp == 3);
            end
            nrsp++;
         end
         tick();
      end
      n_tests++;
      if (nacc != 4 || nrsp != 4) begin
         n_fail++;
         $display("FAIL rdburst_count: accesses=%0d responses=%0d, required 4 4", nacc, nrsp);
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_sweep();
      test_abort();
      test_back_to_back();
`ifdef RAM_BURST_EN
      test_burst();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
